// File: rtl/codec_responder_if.sv
// Link bundle between the digital-core side (master) and the codec responder (slave):
// I2S-style pins plus the parallel ADC source / DAC sink words.
interface codec_responder_if #(
    parameter int DATA_W = 16
);
    logic                     LRCLK;
    logic                     SCLK;
    logic                     RSTn;
    logic                     SDin;
    logic                     SDout;
    logic signed [DATA_W-1:0] adc_lft;
    logic signed [DATA_W-1:0] adc_rht;
    logic                     adc_req;
    logic signed [DATA_W-1:0] dac_lft;
    logic signed [DATA_W-1:0] dac_rht;
    logic                     dac_valid;
    logic                     frame_err;

    modport master (
        output LRCLK, SCLK, RSTn, SDin, adc_lft, adc_rht,
        input  SDout, adc_req, dac_lft, dac_rht, dac_valid, frame_err
    );

    modport slave (
        input  LRCLK, SCLK, RSTn, SDin, adc_lft, adc_rht,
        output SDout, adc_req, dac_lft, dac_rht, dac_valid, frame_err
    );
endinterface

// File: rtl/codec_responder.sv
// Codec-side end of an I2S-style link: deserialises SDin into L/R DAC words, serialises ADC words onto SDout.
// Optional macro LOOPBACK_EN: transmit the received DAC words instead of adc_lft/adc_rht.
module codec_responder #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    codec_responder_if.slave lnk
);
    localparam int               CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // One shared chain for {LRCLK, SCLK, RSTn, SDin} keeps the pin edges aligned.
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic                        lr_prev_q, lr_prev_d;
    logic                        sck_prev_q, sck_prev_d;

    logic s_lr, s_sck, s_rstn, s_sd;
    logic lr_rise, lr_fall, lr_edge;
    logic sck_rise, sck_fall;

    state_e state_q, state_d;
    logic   link_active;
    logic   link_run;

    logic        [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic        [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic        [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic signed [DATA_W-1:0] dac_lft_q, dac_lft_d;
    logic signed [DATA_W-1:0] dac_rht_q, dac_rht_d;
    logic                     lft_ok_q, lft_ok_d;
    logic                     dac_valid_q, dac_valid_d;
    logic                     adc_req_q, adc_req_d;
    logic                     frame_err_q, frame_err_d;
    logic        [DATA_W-1:0] word_lft;
    logic        [DATA_W-1:0] word_rht;
`ifndef LOOPBACK_EN
    logic signed [DATA_W-1:0] rht_hold_q, rht_hold_d;
`endif

    always_comb begin
        sync_d[0] = {lnk.LRCLK, lnk.SCLK, lnk.RSTn, lnk.SDin};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_lr   = sync_q[SYNC_STAGES-1][3];
    assign s_sck  = sync_q[SYNC_STAGES-1][2];
    assign s_rstn = sync_q[SYNC_STAGES-1][1];
    assign s_sd   = sync_q[SYNC_STAGES-1][0];

    assign lr_prev_d  = s_lr;
    assign sck_prev_d = s_sck;

    assign lr_rise  = s_lr & ~lr_prev_q;
    assign lr_fall  = ~s_lr & lr_prev_q;
    assign lr_edge  = lr_rise | lr_fall;
    assign sck_rise = s_sck & ~sck_prev_q;
    assign sck_fall = ~s_sck & sck_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // ALIGN covers the partial slot after reset release; the first LRCLK edge is only a marker.
    always_comb begin
        state_d = state_q;
        if (!s_rstn) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD:  state_d = ST_ALIGN;
                ST_ALIGN: if (lr_edge) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        link_active = 1'b0;
        link_run    = 1'b0;
        case (state_q)
            ST_ALIGN: link_active = s_rstn;
            ST_RUN: begin
                link_active = s_rstn;
                link_run    = s_rstn;
            end
            default: ;
        endcase
    end

`ifdef LOOPBACK_EN
    assign word_lft = dac_lft_q;
    assign word_rht = dac_rht_q;
`else
    assign word_lft = lnk.adc_lft;
    assign word_rht = rht_hold_q;
`endif

    always_comb begin
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        dac_lft_d   = dac_lft_q;
        dac_rht_d   = dac_rht_q;
        lft_ok_d    = lft_ok_q;
        dac_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (!link_active) begin
            rx_sh_d   = '0;
            bit_cnt_d = '0;
            lft_ok_d  = 1'b0;
        end else begin
            if (lr_edge) begin
                rx_sh_d   = '0;
                bit_cnt_d = '0;
                if (link_run) begin
                    frame_err_d = (bit_cnt_q != CNT_FULL);
                    if (lr_fall) begin
                        dac_lft_d = rx_sh_q;
                        lft_ok_d  = 1'b1;
                    end else begin
                        dac_rht_d   = rx_sh_q;
                        dac_valid_d = lft_ok_q;
                    end
                end
            end
            // An SCLK rise coinciding with an LRCLK edge lands as bit 1 of the new slot.
            if (sck_rise) begin
                rx_sh_d = {rx_sh_d[DATA_W-2:0], s_sd};
                if (bit_cnt_d != CNT_SAT) begin
                    bit_cnt_d = bit_cnt_d + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        tx_sh_d   = tx_sh_q;
        adc_req_d = 1'b0;
`ifndef LOOPBACK_EN
        rht_hold_d = rht_hold_q;
`endif
        if (!link_active) begin
            tx_sh_d = '0;
        end else if (lr_rise) begin
            tx_sh_d   = word_lft;
            adc_req_d = 1'b1;
`ifndef LOOPBACK_EN
            rht_hold_d = lnk.adc_rht;
`endif
        end else if (lr_fall) begin
            tx_sh_d = word_rht;
        end else if (sck_fall) begin
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            lr_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            tx_sh_q     <= '0;
            dac_lft_q   <= '0;
            dac_rht_q   <= '0;
            lft_ok_q    <= 1'b0;
            dac_valid_q <= 1'b0;
            adc_req_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifndef LOOPBACK_EN
            rht_hold_q  <= '0;
`endif
        end else begin
            sync_q      <= sync_d;
            lr_prev_q   <= lr_prev_d;
            sck_prev_q  <= sck_prev_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sh_q     <= tx_sh_d;
            dac_lft_q   <= dac_lft_d;
            dac_rht_q   <= dac_rht_d;
            lft_ok_q    <= lft_ok_d;
            dac_valid_q <= dac_valid_d;
            adc_req_q   <= adc_req_d;
            frame_err_q <= frame_err_d;
`ifndef LOOPBACK_EN
            rht_hold_q  <= rht_hold_d;
`endif
        end
    end

    assign lnk.SDout     = tx_sh_q[DATA_W-1];
    assign lnk.dac_lft   = dac_lft_q;
    assign lnk.dac_rht   = dac_rht_q;
    assign lnk.dac_valid = dac_valid_q;
    assign lnk.adc_req   = adc_req_q;
    assign lnk.frame_err = frame_err_q;

endmodule

// File: tb/tb_codec_responder.sv
// Directed bench for codec_responder: acts as the link master (SCLK = clk/32, LRCLK = clk/1024).
// Build with LOOPBACK_EN defined to check the echo path expectations instead of the ADC words.
module tb_codec_responder;
    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_req   = 0;
    int b_valid, b_err, b_req;

    logic [15:0] rd_l, rd_r, rd_x, sdo_or;

    codec_responder_if #(.DATA_W(16)) lnk ();

    codec_responder #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (lnk.dac_valid === 1'b1) n_valid <= n_valid + 1;
        if (lnk.frame_err === 1'b1) n_err   <= n_err + 1;
        if (lnk.adc_req === 1'b1)   n_req   <= n_req + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_err   = n_err;
        b_req   = n_req;
    endtask

    // One slot of nbits SCLK periods; LRCLK and SDin change with the SCLK fall, SDout read at the rise.
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits,
                             output logic [15:0] rd);
        rd = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            lnk.SCLK = 1'b0;
            if (i == nbits - 1) lnk.LRCLK = lr;
            lnk.SDin = word[i];
            tick(16);
            rd = {rd[14:0], lnk.SDout};
            lnk.SCLK = 1'b1;
            tick(16);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_sdout"},  {31'd0, lnk.SDout}, 32'd0);
        check_eq({tag, "_daclft"}, {16'd0, lnk.dac_lft}, 32'd0);
        check_eq({tag, "_dacrht"}, {16'd0, lnk.dac_rht}, 32'd0);
        check_eq({tag, "_valid"},  {31'd0, lnk.dac_valid}, 32'd0);
        check_eq({tag, "_req"},    {31'd0, lnk.adc_req}, 32'd0);
        check_eq({tag, "_ferr"},   {31'd0, lnk.frame_err}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        lnk.LRCLK   = 1'b0;
        lnk.SCLK    = 1'b1;
        lnk.RSTn    = 1'b0;
        lnk.SDin    = 1'b0;
        lnk.adc_lft = '0;
        lnk.adc_rht = '0;
        tick(5);
        check_outputs_zero("rst");

        rst         = 1'b0;
        lnk.RSTn    = 1'b1;
        lnk.adc_lft = 16'sh8001;
        lnk.adc_rht = 16'sh7FFE;
        tick(10);

        // First pair after reset: A55A / 1234 in, 8001 / 7FFE out.
        snap();
        send_slot(1'b1, 16'hA55A, 16, rd_l);
        send_slot(1'b0, 16'h1234, 16, rd_r);
`ifndef LOOPBACK_EN
        check_eq("sdo_left_8001",  {16'd0, rd_l}, 32'h8001);
        check_eq("sdo_right_7ffe", {16'd0, rd_r}, 32'h7FFE);
`endif
        check_eq("dac_lft_a55a", {16'd0, lnk.dac_lft}, 32'hA55A);

        // Right word must be the one latched at the LRCLK rise, not the mid-slot update.
        lnk.adc_lft = 16'sh1111;
        lnk.adc_rht = 16'sh2222;
        fork
            send_slot(1'b1, 16'h5A5A, 16, rd_l);
            begin
                tick(100);
                lnk.adc_rht = 16'shBEEF;
            end
        join
        check_eq("dac_rht_1234", {16'd0, lnk.dac_rht}, 32'h1234);
        check_eq("valid_first_pair", n_valid - b_valid, 1);
        check_eq("req_two_frames", n_req - b_req, 2);
        check_eq("ferr_clean", n_err - b_err, 0);
        send_slot(1'b0, 16'hC3C3, 16, rd_r);
`ifndef LOOPBACK_EN
        check_eq("sdo_left_1111",     {16'd0, rd_l}, 32'h1111);
        check_eq("sdo_right_coherent", {16'd0, rd_r}, 32'h2222);
`endif
        check_eq("dac_lft_5a5a", {16'd0, lnk.dac_lft}, 32'h5A5A);

        // Truncated left slot: 15 bits of 1ABC, then clean frames.
        snap();
        send_slot(1'b1, 16'h1ABC, 15, rd_x);
        send_slot(1'b0, 16'h0F00, 16, rd_x);
        check_eq("trunc_ferr_one", n_err - b_err, 1);
        check_eq("trunc_dac_lft", {16'd0, lnk.dac_lft}, 32'h1ABC);
        send_slot(1'b1, 16'h2345, 16, rd_x);
        send_slot(1'b0, 16'h6789, 16, rd_x);
        send_slot(1'b1, 16'h0F0F, 16, rd_x);
        check_eq("trunc_ferr_after", n_err - b_err, 1);
        check_eq("trunc_valid_cnt", n_valid - b_valid, 3);
        check_eq("dac_lft_2345", {16'd0, lnk.dac_lft}, 32'h2345);
        check_eq("dac_rht_6789", {16'd0, lnk.dac_rht}, 32'h6789);

        // Echo frame: 0F0F / F0F0 received, next frame transmits either those or the ADC words.
        lnk.adc_lft = 16'sh1357;
        lnk.adc_rht = 16'sh2468;
        send_slot(1'b0, 16'hF0F0, 16, rd_x);
        send_slot(1'b1, 16'h0000, 16, rd_l);
        send_slot(1'b0, 16'h0000, 16, rd_r);
        check_eq("dac_rht_f0f0", {16'd0, lnk.dac_rht}, 32'hF0F0);
`ifdef LOOPBACK_EN
        check_eq("echo_left",  {16'd0, rd_l}, 32'h0F0F);
        check_eq("echo_right", {16'd0, rd_r}, 32'hF0F0);
`else
        check_eq("adc_left_1357",  {16'd0, rd_l}, 32'h1357);
        check_eq("adc_right_2468", {16'd0, rd_r}, 32'h2468);
`endif

        // Codec reset dropped mid-left-slot for three frames, released mid-left-slot.
        fork
            send_slot(1'b1, 16'h1111, 16, rd_x);
            begin
                tick(256);
                lnk.RSTn = 1'b0;
                tick(20);
                snap();
            end
        join
        sdo_or = '0;
        for (int k = 0; k < 5; k++) begin
            send_slot(k[0] ? 1'b1 : 1'b0, 16'hFFFF, 16, rd_x);
            sdo_or = sdo_or | rd_x;
        end
        fork
            send_slot(1'b1, 16'h2222, 16, rd_x);
            begin
                tick(256);
                lnk.RSTn = 1'b1;
            end
        join
        check_eq("codec_rst_sdout", {16'd0, sdo_or}, 32'd0);
        check_eq("codec_rst_valid", n_valid - b_valid, 0);
        check_eq("codec_rst_ferr", n_err - b_err, 0);
        check_eq("codec_rst_req", n_req - b_req, 0);
        send_slot(1'b0, 16'hAAAA, 16, rd_x);
        send_slot(1'b1, 16'h5555, 16, rd_x);
        check_eq("release_no_valid_yet", n_valid - b_valid, 0);
        send_slot(1'b0, 16'h3C3C, 16, rd_x);
        send_slot(1'b1, 16'h0000, 16, rd_x);
        check_eq("release_valid", n_valid - b_valid, 1);
        check_eq("release_ferr", n_err - b_err, 0);
        check_eq("release_dac_lft", {16'd0, lnk.dac_lft}, 32'h5555);
        check_eq("release_dac_rht", {16'd0, lnk.dac_rht}, 32'h3C3C);

        // System reset mid-frame, then recovery over one full frame.
        fork
            send_slot(1'b0, 16'h1234, 16, rd_x);
            begin
                tick(200);
                rst = 1'b1;
                tick(1);
                check_outputs_zero("midrst");
                rst = 1'b0;
            end
        join
        snap();
        send_slot(1'b1, 16'h4444, 16, rd_x);
        send_slot(1'b0, 16'h8888, 16, rd_x);
        send_slot(1'b1, 16'h0000, 16, rd_x);
        check_eq("recover_ferr", n_err - b_err, 0);
        check_eq("recover_valid", n_valid - b_valid, 1);
        check_eq("recover_dac_lft", {16'd0, lnk.dac_lft}, 32'h4444);
        check_eq("recover_dac_rht", {16'd0, lnk.dac_rht}, 32'h8888);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
